instr_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 10-bit processor datapath.
- Owns the instruction register and the T-step counter.
- Decodes a fetched instruction into per-step control for the register file, ALU A/G registers, immediate driver and external-data driver.
- Guarantees at most one driver on the shared 10-bit bus per cycle. Replaces the separate controller/upcount2 pairing with a single reset-able FSM.

---
 rtl/instr_sequencer_if.sv | 56 +++++
 rtl/instr_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Bus / control bundle between instr_sequencer and the datapath.
//               HALTED is present only when SEQ_HALT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] BUS;
    logic              GO;
    logic [DATA_W-1:0] IR;
    logic [1:0]        T;
    logic              Ext;
    logic              IRin;
    logic              ENR;
    logic [1:0]        RDA;
    logic              ENW;
    logic [1:0]        WRA;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [3:0]        FN;
    logic              IMMen;
    logic [DATA_W-1:0] IMM;
    logic              DONE;
    logic              BUSY;
    logic              ILLEGAL;
`ifdef SEQ_HALT_EN
    logic              HALTED;

    modport master (
        input  BUS, GO,
        output IR, T, Ext, IRin, ENR, RDA, ENW, WRA, Ain, Gin, Gout, FN,
               IMMen, IMM, DONE, BUSY, ILLEGAL, HALTED
    );
    modport slave (
        output BUS, GO,
        input  IR, T, Ext, IRin, ENR, RDA, ENW, WRA, Ain, Gin, Gout, FN,
               IMMen, IMM, DONE, BUSY, ILLEGAL, HALTED
    );
`else
    modport master (
        input  BUS, GO,
        output IR, T, Ext, IRin, ENR, RDA, ENW, WRA, Ain, Gin, Gout, FN,
               IMMen, IMM, DONE, BUSY, ILLEGAL
    );
    modport slave (
        output BUS, GO,
        input  IR, T, Ext, IRin, ENR, RDA, ENW, WRA, Ain, Gin, Gout, FN,
               IMMen, IMM, DONE, BUSY, ILLEGAL
    );
`endif
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle FETCH/EX1..EX3 sequencer for the 10-bit datapath.
//               Optional macro SEQ_HALT_EN turns opcode 1001 into HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int DATA_W     = 10,
    parameter bit IMM_SIGNED = 1'b0
) (
    input  logic               CLKb,
    input  logic               RSTn,
    instr_sequencer_if.master  sif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EX1    = 3'd1,
        S_EX2    = 3'd2,
        S_EX3    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        w_opcode;
    logic [1:0]        w_rx, w_ry;
    logic [3:0]        w_imm4;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_is_ld, w_is_mov, w_is_alu_r, w_is_ldi, w_is_alu_i, w_is_halt;

    logic              w_ext, w_irin, w_enr, w_enw, w_ain, w_gin, w_gout, w_immen, w_done;
    logic [1:0]        w_rda, w_wra;
    logic [3:0]        w_fn;

    assign w_opcode = ir_q[9:6];
    assign w_rx     = ir_q[5:4];
    assign w_ry     = ir_q[3:2];
    assign w_imm4   = ir_q[3:0];

    if (IMM_SIGNED) begin : g_imm_sext
        assign w_imm_ext = {{(DATA_W-4){w_imm4[3]}}, w_imm4};
    end else begin : g_imm_zext
        assign w_imm_ext = {{(DATA_W-4){1'b0}}, w_imm4};
    end

    always_comb begin
        w_is_ld    = (w_opcode == 4'd0);
        w_is_mov   = (w_opcode == 4'd1);
        w_is_alu_r = (w_opcode >= 4'd2)  && (w_opcode <= 4'd6);
        w_is_ldi   = (w_opcode == 4'd8);
        w_is_alu_i = (w_opcode >= 4'd10) && (w_opcode <= 4'd14);
`ifdef SEQ_HALT_EN
        w_is_halt  = (w_opcode == 4'd9);
`else
        w_is_halt  = 1'b0;
`endif
    end

    // Every bus driver is asserted in exactly one branch, so at most one is high.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        w_ext     = 1'b0;
        w_irin    = 1'b0;
        w_enr     = 1'b0;
        w_rda     = 2'd0;
        w_enw     = 1'b0;
        w_wra     = 2'd0;
        w_ain     = 1'b0;
        w_gin     = 1'b0;
        w_gout    = 1'b0;
        w_fn      = 4'd0;
        w_immen   = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // RSTn gate keeps the GO-dependent outputs quiet while in reset.
                if (sif.GO && RSTn) begin
                    w_ext   = 1'b1;
                    w_irin  = 1'b1;
                    ir_d    = sif.BUS;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                if (w_is_ld) begin
                    w_ext  = 1'b1;
                    w_enw  = 1'b1;
                    w_wra  = w_rx;
                    w_done = 1'b1;
                end else if (w_is_mov) begin
                    w_enr  = 1'b1;
                    w_rda  = w_ry;
                    w_enw  = 1'b1;
                    w_wra  = w_rx;
                    w_done = 1'b1;
                end else if (w_is_alu_r || w_is_alu_i) begin
                    w_enr  = 1'b1;
                    w_rda  = w_rx;
                    w_ain  = 1'b1;
                end else if (w_is_ldi) begin
                    w_immen = 1'b1;
                    w_enw   = 1'b1;
                    w_wra   = w_rx;
                    w_done  = 1'b1;
                end else if (w_is_halt) begin
                    w_done  = 1'b1;
                end else begin
                    w_done    = 1'b1;
                    illegal_d = 1'b1;
                end
                if (w_is_halt)
                    state_d = S_HALTED;
                else if (w_done)
                    state_d = S_FETCH;
                else
                    state_d = S_EX2;
            end
            S_EX2: begin
                state_d = S_EX3;
                if (w_is_alu_r) begin
                    w_enr = 1'b1;
                    w_rda = w_ry;
                    w_gin = 1'b1;
                    w_fn  = w_opcode - 4'd2;
                end else if (w_is_alu_i) begin
                    w_immen = 1'b1;
                    w_gin   = 1'b1;
                    w_fn    = w_opcode - 4'd10;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EX3: begin
                w_gout  = 1'b1;
                w_enw   = 1'b1;
                w_wra   = w_rx;
                w_done  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLKb or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    assign sif.IR      = ir_q;
    assign sif.T       = (state_q == S_EX1) ? 2'd1 :
                         (state_q == S_EX2) ? 2'd2 :
                         (state_q == S_EX3) ? 2'd3 : 2'd0;
    assign sif.Ext     = w_ext;
    assign sif.IRin    = w_irin;
    assign sif.ENR     = w_enr;
    assign sif.RDA     = w_rda;
    assign sif.ENW     = w_enw;
    assign sif.WRA     = w_wra;
    assign sif.Ain     = w_ain;
    assign sif.Gin     = w_gin;
    assign sif.Gout    = w_gout;
    assign sif.FN      = w_fn;
    assign sif.IMMen   = w_immen;
    assign sif.IMM     = w_immen ? w_imm_ext : '0;
    assign sif.DONE    = w_done;
    assign sif.BUSY    = (state_q != S_FETCH);
    assign sif.ILLEGAL = illegal_q;
`ifdef SEQ_HALT_EN
    assign sif.HALTED  = (state_q == S_HALTED);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer (zero- and
//               sign-extending instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam logic [9:0] M_EXT   = 10'h200;
    localparam logic [9:0] M_IRIN  = 10'h100;
    localparam logic [9:0] M_ENR   = 10'h080;
    localparam logic [9:0] M_ENW   = 10'h040;
    localparam logic [9:0] M_AIN   = 10'h020;
    localparam logic [9:0] M_GIN   = 10'h010;
    localparam logic [9:0] M_GOUT  = 10'h008;
    localparam logic [9:0] M_IMMEN = 10'h004;
    localparam logic [9:0] M_DONE  = 10'h002;
    localparam logic [9:0] M_BUSY  = 10'h001;

    logic       clk = 1'b0;
    logic       rstn;
    logic       go;
    logic [9:0] bus;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.DATA_W(10)) if_u ();
    instr_sequencer_if #(.DATA_W(10)) if_s ();

    assign if_u.BUS = bus;
    assign if_u.GO  = go;
    assign if_s.BUS = bus;
    assign if_s.GO  = go;

    instr_sequencer #(.DATA_W(10), .IMM_SIGNED(1'b0)) u_dut_u (
        .CLKb (clk),
        .RSTn (rstn),
        .sif  (if_u)
    );

    instr_sequencer #(.DATA_W(10), .IMM_SIGNED(1'b1)) u_dut_s (
        .CLKb (clk),
        .RSTn (rstn),
        .sif  (if_s)
    );

    logic [9:0] en_u;
    assign en_u = {if_u.Ext, if_u.IRin, if_u.ENR, if_u.ENW, if_u.Ain,
                   if_u.Gin, if_u.Gout, if_u.IMMen, if_u.DONE, if_u.BUSY};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ctrl(input string tag, input logic [9:0] en, input logic [1:0] rda,
                               input logic [1:0] wra, input logic [3:0] fn,
                               input logic [1:0] t, input logic [9:0] imm);
        check({tag, ".en"},  32'(en_u),      32'(en));
        check({tag, ".rda"}, 32'(if_u.RDA),  32'(rda));
        check({tag, ".wra"}, 32'(if_u.WRA),  32'(wra));
        check({tag, ".fn"},  32'(if_u.FN),   32'(fn));
        check({tag, ".t"},   32'(if_u.T),    32'(t));
        check({tag, ".imm"}, 32'(if_u.IMM),  32'(imm));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(input logic [9:0] instr);
        bus = instr;
        go  = 1'b1;
        tick();
        go  = 1'b0;
        bus = 10'h000;
    endtask

    function automatic int exp_len(input logic [3:0] op);
        return ((op >= 4'd2 && op <= 4'd6) || (op >= 4'd10 && op <= 4'd14)) ? 3 : 1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        logic [9:0] instr;
        int         cycles;

        rstn = 1'b0;
        go   = 1'b0;
        bus  = 10'h000;
        #12;
        expect_ctrl("rst", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
        check("rst.ir", 32'(if_u.IR), 32'h0);
        check("rst.illegal", 32'(if_u.ILLEGAL), 32'h0);
        go = 1'b1;
        #1;
        check("rst.go_masked", 32'(en_u), 32'h0);
        go   = 1'b0;
        rstn = 1'b1;
        tick();

        // LD R1
        bus = 10'h010;
        go  = 1'b1;
        #1;
        expect_ctrl("ld.fetch", M_EXT | M_IRIN, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
        tick();
        go  = 1'b0;
        bus = 10'h000;
        check("ld.ir", 32'(if_u.IR), 32'h010);
        expect_ctrl("ld.ex1", M_EXT | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd1, 4'd0, 2'd1, 10'h000);
        tick();
        expect_ctrl("ld.back", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);

        // ADD R1,R2
        run_fetch(10'h098);
        expect_ctrl("add.ex1", M_ENR | M_AIN | M_BUSY, 2'd1, 2'd0, 4'd0, 2'd1, 10'h000);
        tick();
        expect_ctrl("add.ex2", M_ENR | M_GIN | M_BUSY, 2'd2, 2'd0, 4'd0, 2'd2, 10'h000);
        tick();
        expect_ctrl("add.ex3", M_GOUT | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd1, 4'd0, 2'd3, 10'h000);
        tick();
        expect_ctrl("add.back", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);

        // XOR R0,R3
        run_fetch(10'h18C);
        expect_ctrl("xor.ex1", M_ENR | M_AIN | M_BUSY, 2'd0, 2'd0, 4'd0, 2'd1, 10'h000);
        tick();
        expect_ctrl("xor.ex2", M_ENR | M_GIN | M_BUSY, 2'd3, 2'd0, 4'd4, 2'd2, 10'h000);
        tick();
        expect_ctrl("xor.ex3", M_GOUT | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd0, 4'd0, 2'd3, 10'h000);
        tick();

        // ADDI R3,#5
        run_fetch(10'h2B5);
        expect_ctrl("addi.ex1", M_ENR | M_AIN | M_BUSY, 2'd3, 2'd0, 4'd0, 2'd1, 10'h000);
        tick();
        expect_ctrl("addi.ex2", M_IMMEN | M_GIN | M_BUSY, 2'd0, 2'd0, 4'd0, 2'd2, 10'h005);
        check("addi.imm_s", 32'(if_s.IMM), 32'h005);
        tick();
        expect_ctrl("addi.ex3", M_GOUT | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd3, 4'd0, 2'd3, 10'h000);
        tick();

        // ADDI R3,#-1: zero vs sign extension
        run_fetch(10'h2BF);
        tick();
        check("addi_f.imm_u", 32'(if_u.IMM), 32'h00F);
        check("addi_f.imm_s", 32'(if_s.IMM), 32'h3FF);
        tick();
        tick();

        // LDI R2,#9 and MOV R3,R1
        run_fetch(10'h229);
        expect_ctrl("ldi.ex1", M_IMMEN | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd2, 4'd0, 2'd1, 10'h009);
        tick();
        run_fetch(10'h074);
        expect_ctrl("mov.ex1", M_ENR | M_ENW | M_DONE | M_BUSY, 2'd1, 2'd3, 4'd0, 2'd1, 10'h000);
        tick();

        // Idle in FETCH with bus activity but no GO
        bus = 10'h155;
        for (int i = 0; i < 5; i++) begin
            expect_ctrl("idle", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
            check("idle.ir", 32'(if_u.IR), 32'h074);
            tick();
        end

        // Illegal 1111, then ILLEGAL stays set through an LD
        run_fetch(10'h3C0);
        expect_ctrl("ill.ex1", M_DONE | M_BUSY, 2'd0, 2'd0, 4'd0, 2'd1, 10'h000);
        check("ill.ex1_flag", 32'(if_u.ILLEGAL), 32'h0);
        tick();
        check("ill.flag", 32'(if_u.ILLEGAL), 32'h1);
        expect_ctrl("ill.back", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
        run_fetch(10'h020);
        expect_ctrl("ld2.ex1", M_EXT | M_ENW | M_DONE | M_BUSY, 2'd0, 2'd2, 4'd0, 2'd1, 10'h000);
        tick();
        check("ill.sticky", 32'(if_u.ILLEGAL), 32'h1);

        // Reset in EX2 of SUB R1,R2
        run_fetch(10'h0D8);
        expect_ctrl("sub.ex1", M_ENR | M_AIN | M_BUSY, 2'd1, 2'd0, 4'd0, 2'd1, 10'h000);
        tick();
        expect_ctrl("sub.ex2", M_ENR | M_GIN | M_BUSY, 2'd2, 2'd0, 4'd1, 2'd2, 10'h000);
        #2;
        rstn = 1'b0;
        #1;
        expect_ctrl("sub.rst", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
        check("sub.rst_ir", 32'(if_u.IR), 32'h0);
        check("sub.rst_ill", 32'(if_u.ILLEGAL), 32'h0);
        tick();
        check("sub.rst_hold", 32'(en_u), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("sub.after", 32'(en_u), 32'h0);

        // Random instruction stream
        for (int n = 0; n < 1000; n++) begin
            instr = 10'($urandom_range(0, 1023));
`ifdef SEQ_HALT_EN
            if (instr[9:6] == 4'd9)
                instr[9:6] = 4'd0;
`endif
            run_fetch(instr);
            cycles = 0;
            for (int c = 1; c <= 4; c++) begin
                cycles = c;
                check("rnd.bus1hot",
                      32'($countones({if_u.Ext, if_u.ENR, if_u.Gout, if_u.IMMen}) <= 1), 32'h1);
                if (if_u.DONE)
                    break;
                tick();
            end
            check("rnd.len", 32'(cycles), 32'(exp_len(instr[9:6])));
            tick();
            check("rnd.fetch", 32'(if_u.BUSY), 32'h0);
        end

        // Opcode 1001 from a clean reset
        do_reset();
        check("op9.ill0", 32'(if_u.ILLEGAL), 32'h0);
        run_fetch(10'h240);
        expect_ctrl("op9.ex1", M_DONE | M_BUSY, 2'd0, 2'd0, 4'd0, 2'd1, 10'h000);
        tick();
`ifdef SEQ_HALT_EN
        check("halt.flag", 32'(if_u.HALTED), 32'h1);
        check("halt.ill", 32'(if_u.ILLEGAL), 32'h0);
        bus = 10'h010;
        go  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_ctrl("halt.hold", M_BUSY, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
            check("halt.ir", 32'(if_u.IR), 32'h240);
            tick();
        end
        go = 1'b0;
        do_reset();
        check("halt.cleared", 32'(if_u.HALTED), 32'h0);
        check("halt.busy0", 32'(if_u.BUSY), 32'h0);
`else
        check("op9.ill", 32'(if_u.ILLEGAL), 32'h1);
        expect_ctrl("op9.back", 10'h000, 2'd0, 2'd0, 4'd0, 2'd0, 10'h000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
